// File: rtl/hood_pkg.sv
// hood_pkg: shared definitions for the range-hood mode sequencer and datapath.
//   - MODE_* : mode_state encoding seen by the timing/display datapath
//   - DEF_*  : default prescaler ratio and timed-mode durations (seconds)
//   - state_e: sequencer state type, encoded directly as the mode_state code
package hood_pkg;

    localparam logic [2:0] MODE_STANDBY   = 3'd0;
    localparam logic [2:0] MODE_GEAR1     = 3'd1;
    localparam logic [2:0] MODE_GEAR2     = 3'd2;
    localparam logic [2:0] MODE_HURRICANE = 3'd3;
    localparam logic [2:0] MODE_CLEAN     = 3'd4;
    localparam logic [2:0] MODE_EXIT      = 3'd5;
    localparam logic [2:0] MODE_OFF       = 3'd7;

    localparam int unsigned DEF_TICKS_PER_SEC = 500;
    localparam int unsigned DEF_HURRICANE_S   = 60;
    localparam int unsigned DEF_CLEAN_S       = 180;
    localparam int unsigned DEF_EXIT_S        = 60;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned CD_W   = 8;

    typedef enum logic [MODE_W-1:0] {
        ST_STANDBY   = MODE_STANDBY,
        ST_GEAR1     = MODE_GEAR1,
        ST_GEAR2     = MODE_GEAR2,
        ST_HURRICANE = MODE_HURRICANE,
        ST_CLEAN     = MODE_CLEAN,
        ST_EXIT      = MODE_EXIT,
        ST_OFF       = MODE_OFF
    } state_e;

    // States that run a seconds countdown and leave on expiry.
    function automatic logic is_timed(input state_e s);
        return (s == ST_HURRICANE) || (s == ST_CLEAN) || (s == ST_EXIT);
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: divides clk down to a once-per-second wrap indication.
//   clk   : system clock
//   rst   : synchronous active-low reset
//   clr   : restart the count at 0 (takes priority over en)
//   en    : count while high; count is held at 0 while low
//   tick  : combinational, high in the cycle whose edge wraps the count;
//           the owner registers it so it lines up with its own state update
module sec_prescaler
    import hood_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned        CNT_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_MAX);

    // Next count: clear wins, then hold-at-zero when disabled, then wrap/increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood mode sequencer.
//   clk, rst                 : clock, synchronous active-low reset
//   power_on                 : power switch level
//   menu/mode1/mode2/mode3/clean_btn : debounced one-cycle button pulses
//   mode_state     (3)       : current mode code (hood_pkg MODE_*)
//   countdown_sec  (8)       : seconds left in HURRICANE/CLEAN/EXIT, else 0
//   sec_tick                 : one-cycle pulse per second while powered
//   hurricane_used           : hurricane gear consumed this power cycle
//   clean_done               : one-cycle pulse as CLEAN returns to STANDBY
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int unsigned HURRICANE_S   = DEF_HURRICANE_S,
    parameter int unsigned CLEAN_S       = DEF_CLEAN_S,
    parameter int unsigned EXIT_S        = DEF_EXIT_S
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_on,
    input  logic              menu_btn,
    input  logic              mode1_btn,
    input  logic              mode2_btn,
    input  logic              mode3_btn,
    input  logic              clean_btn,
    output logic [MODE_W-1:0] mode_state,
    output logic [CD_W-1:0]   countdown_sec,
    output logic              sec_tick,
    output logic              hurricane_used,
    output logic              clean_done
);

    state_e            state_q, state_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic              armed_q, armed_d;
    logic              hu_q, hu_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              wrap;
    logic              state_chg;
    logic              expire;

    // Prescaler restarts on every state change so each state gets full seconds.
    sec_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_chg),
        .en   (state_q != ST_OFF),
        .tick (wrap)
    );

    assign state_chg = (state_d != state_q);
    assign expire    = wrap && (cd_q == CD_W'(1));

    // Next state, countdown and flag updates; button priority menu > mode3 > mode2 > mode1 > clean.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        hu_d    = hu_q;
        cd_d    = cd_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        if (!power_on) begin
            state_d = ST_OFF;
            armed_d = 1'b0;
            hu_d    = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_STANDBY;
                ST_STANDBY: begin
                    if (menu_btn) begin
                        armed_d = !armed_q;
                    end else if (armed_q) begin
                        // A refused hurricane request leaves the menu armed.
                        if (mode3_btn) begin
                            if (!hu_q) begin
                                state_d = ST_HURRICANE;
                                armed_d = 1'b0;
                            end
                        end else if (mode2_btn) begin
                            state_d = ST_GEAR2;
                            armed_d = 1'b0;
                        end else if (mode1_btn) begin
                            state_d = ST_GEAR1;
                            armed_d = 1'b0;
                        end else if (clean_btn) begin
                            state_d = ST_CLEAN;
                            armed_d = 1'b0;
                        end
                    end
                end
                ST_GEAR1, ST_GEAR2: begin
                    if (menu_btn) begin
                        state_d = ST_EXIT;
                    end else if (mode3_btn) begin
                        if (!hu_q) state_d = ST_HURRICANE;
                    end else if (mode2_btn) begin
                        state_d = ST_GEAR2;
                    end else if (mode1_btn) begin
                        state_d = ST_GEAR1;
                    end
                end
                ST_HURRICANE: begin
                    if (menu_btn)    state_d = ST_EXIT;
                    else if (expire) state_d = ST_GEAR2;
                end
                ST_CLEAN, ST_EXIT: begin
                    if (expire) state_d = ST_STANDBY;
                end
                default: state_d = ST_OFF;
            endcase
        end

        if ((state_d == ST_HURRICANE) && (state_q != ST_HURRICANE)) begin
            hu_d = 1'b1;
        end

        if (state_d != state_q) begin
            case (state_d)
                ST_HURRICANE: cd_d = CD_W'(HURRICANE_S);
                ST_CLEAN:     cd_d = CD_W'(CLEAN_S);
                ST_EXIT:      cd_d = CD_W'(EXIT_S);
                default:      cd_d = '0;
            endcase
        end else if (wrap && is_timed(state_q)) begin
            cd_d = cd_q - CD_W'(1);
        end

        // The tick that causes a state change is swallowed with the prescaler restart.
        tick_d = wrap && (state_d == state_q);
        done_d = (state_q == ST_CLEAN) && (state_d == ST_STANDBY);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_OFF;
            cd_q    <= '0;
            armed_q <= 1'b0;
            hu_q    <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            armed_q <= armed_d;
            hu_q    <= hu_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign mode_state     = state_q;
    assign countdown_sec  = cd_q;
    assign sec_tick       = tick_q;
    assign hurricane_used = hu_q;
    assign clean_done     = done_q;

endmodule
